// File: rtl/dds_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// dds_cmd_sequencer
//
// Buffers host commands for a serial DDS driver and issues them one at a
// time with a trig/ready handshake. Each 38-bit entry is {addr[3:0], cmd[33:0]}.
// The cmd[33:32] field is the opcode: 0 AMP, 1 PHS, 2 FRQ, 3 INIT.
//
// For each command the FSM:
//   - pops the entry,
//   - pulses trig_o for one cycle,
//   - waits for ready_i to fall and then rise,
//   - holds one SETTLE cycle so the driver's IO_UPDATE lands while addr_o is
//     still selected.
//
// Parameters
//   DEPTH_LOG2    FIFO depth is 2**DEPTH_LOG2 entries.
//   TIMEOUT_CYC   Handshake timeout in cycles. Must be >= 1. It is used only
//                 when the macro DDS_SEQ_TIMEOUT_EN is defined.
//
// Optional feature (macro DDS_SEQ_TIMEOUT_EN)
//   Defined:   a stalled handshake sets err_timeout_o and returns the FSM to
//              IDLE.
//   Undefined: the FSM waits indefinitely and err_timeout_o is tied to 0.
//
// Ports
//   iClk           clock, rising edge
//   iReset         synchronous, active-high reset
//   push_i         host write strobe for data_i
//   data_i         {addr[37:34], cmd[33:0]}
//   clr_i          empties the FIFO and clears the sticky flags;
//                  an in-flight command still completes
//   ready_i        driver ready (high = idle / not selected)
//   addr_o         channel select to the driver
//   cmd_o          command word to the driver
//   trig_o         one-cycle command strobe
//   full_o         FIFO full
//   level_o        FIFO occupancy, 0 .. 2**DEPTH_LOG2
//   busy_o         FSM not idle or FIFO not empty
//   overflow_o     sticky: push attempted while full
//   err_timeout_o  sticky: driver handshake timed out
// ---------------------------------------------------------------------------
module dds_cmd_sequencer #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                push_i,
    input  logic [37:0]         data_i,
    input  logic                clr_i,
    input  logic                ready_i,
    output logic [3:0]          addr_o,
    output logic [33:0]         cmd_o,
    output logic                trig_o,
    output logic                full_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                busy_o,
    output logic                overflow_o,
    output logic                err_timeout_o
);

    localparam int unsigned          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_SETTLE
    } state_e;

    state_e                state_q, state_d;

    logic [37:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [3:0]            addr_q, addr_d;
    logic [33:0]           cmd_q, cmd_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push_ok;
    logic                  timeout_hit;
    logic [37:0]           rd_data;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LEVEL_FULL);
    assign rd_data    = mem_q[rd_ptr_q];

    // A pop only happens from IDLE, never on a clear cycle (the clear
    // discards the entry anyway), and never from an empty FIFO. A same-cycle
    // push into an empty FIFO therefore waits one cycle before it is popped.
    assign pop     = (state_q == S_IDLE) && !fifo_empty && !clr_i;

    // A push into a full FIFO is still accepted when a pop frees the slot in
    // the same cycle.
    assign push_ok = push_i && !clr_i && (!fifo_full || pop);

    // ------------------------------------------------------------------
    // FIFO pointer / level / overflow next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push_ok) begin
                level_d = level_q - 1'b1;
            end
            if (push_i && fifo_full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Storage is data only, so it carries no reset.
    always_ff @(posedge iClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM, next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    addr_d  = rd_data[37:34];
                    cmd_d   = rd_data[33:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!ready_i) begin
                    state_d = S_WAIT_HI;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (ready_i) begin
                    state_d = S_SETTLE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            addr_q   <= '0;
            cmd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef DDS_SEQ_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Handshake timeout
    // ------------------------------------------------------------------
    // The counter restarts at 0 on every entry to WAIT_LO or WAIT_HI. It
    // flags the last allowed cycle, so the flag is visible TIMEOUT_CYC
    // cycles after the wait state was entered.
    localparam int unsigned      TMO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;
    logic             in_wait;
    logic             tmo_set;

    assign in_wait     = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
    assign timeout_hit = in_wait && (tmo_cnt_q == TMO_LAST);

    // The timeout only counts when the awaited ready level has not arrived
    // in the same cycle.
    assign tmo_set = timeout_hit &&
                     (((state_q == S_WAIT_LO) && ready_i) ||
                      ((state_q == S_WAIT_HI) && !ready_i));

    always_comb begin
        tmo_cnt_d = '0;
        if (in_wait && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        tmo_d = clr_i ? 1'b0 : (tmo_q | tmo_set);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign err_timeout_o = tmo_q;
`else
    logic timeout_unused;

    assign timeout_hit    = 1'b0;
    assign timeout_unused = ^TIMEOUT_CYC;
    assign err_timeout_o  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign addr_o     = addr_q;
    assign cmd_o      = cmd_q;
    assign trig_o     = (state_q == S_ISSUE);
    assign full_o     = fifo_full;
    assign level_o    = level_q;
    assign busy_o     = (state_q != S_IDLE) || !fifo_empty;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_dds_cmd_sequencer.sv
module tb_dds_cmd_sequencer;

    logic        iClk;
    logic        iReset;
    logic        push_i;
    logic [37:0] data_i;
    logic        clr_i;
    logic        ready_i;
    logic [3:0]  addr_o;
    logic [33:0] cmd_o;
    logic        trig_o;
    logic        full_o;
    logic [2:0]  level_o;
    logic        busy_o;
    logic        overflow_o;
    logic        err_timeout_o;

    dds_cmd_sequencer #(
        .DEPTH_LOG2 (2),
        .TIMEOUT_CYC(10)
    ) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .push_i       (push_i),
        .data_i       (data_i),
        .clr_i        (clr_i),
        .ready_i      (ready_i),
        .addr_o       (addr_o),
        .cmd_o        (cmd_o),
        .trig_o       (trig_o),
        .full_o       (full_o),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .err_timeout_o(err_timeout_o)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;

    // Expected {addr, cmd} in issue order.
    logic [37:0] sb_q[$];
    logic [37:0] mon_exp;

    typedef struct packed {
        logic        push;
        logic        clr;
        logic [37:0] data;
        logic        acc;   // entry expected to reach the driver queue
        logic [2:0]  lvl;
        logic        full;
        logic        ovf;
        logic        trig;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [37:0] mk(input logic [3:0] a, input logic [1:0] op,
                                       input logic [31:0] pl);
        return {a, op, pl};
    endfunction

    function automatic logic [37:0] dv(input int k);
        return mk(4'(k + 1), 2'(k % 4), 32'hA000_0000 + 32'(k));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Scoreboard: every trig_o must present the next expected command.
    always @(negedge iClk) begin
        if (trig_o) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL trig_unexpected: got addr=%0h cmd=%0h expected no trig",
                         addr_o, cmd_o);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({addr_o, cmd_o} !== mon_exp) begin
                    errors++;
                    $display("FAIL trig_cmd: got %0h expected %0h", {addr_o, cmd_o}, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;

        // Vector table: ready_i held low, DEPTH=4
        tbl[0] = '{1'b1, 1'b0, dv(0), 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, dv(1), 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, dv(2), 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, dv(3), 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, dv(4), 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, dv(5), 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, dv(0), 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, dv(6), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, dv(7), 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, dv(0), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        iReset  = 1'b1;
        push_i  = 1'b0;
        data_i  = '0;
        clr_i   = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_trig",  64'(trig_o),  64'd0);
        chk("rst_addr",  64'(addr_o),  64'd0);
        chk("rst_cmd",   64'(cmd_o),   64'd0);
        chk("rst_err",   64'(err_timeout_o), 64'd0);
        iReset = 1'b0;
        tick();

        // Single command latency: push at N -> trig at N+2 only
        data_i = mk(4'h2, 2'd2, 32'h1234_5678);
        push_i = 1'b1;
        sb_q.push_back(data_i);
        tick();
        push_i = 1'b0;
        chk("lat_n1_trig", 64'(trig_o), 64'd0);
        chk("lat_n1_level", 64'(level_o), 64'd1);
        tick();
        chk("lat_n2_trig", 64'(trig_o), 64'd1);
        chk("lat_n2_addr", 64'(addr_o), 64'h2);
        chk("lat_n2_cmd",  64'(cmd_o),  64'h2_1234_5678);
        tick();
        chk("lat_n3_trig", 64'(trig_o), 64'd0);
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        tick();
        chk("lat_settle_busy", 64'(busy_o), 64'd1);
        tick();
        chk("lat_idle_busy", 64'(busy_o), 64'd0);
        chk("lat_hold_addr", 64'(addr_o), 64'h2);

        // Table: fill, overflow, clr with push, clr while in flight
        ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].clr) sb_q.delete();
            if (tbl[i].acc) sb_q.push_back(tbl[i].data);
            push_i = tbl[i].push;
            clr_i  = tbl[i].clr;
            data_i = tbl[i].data;
            tick();
            chk($sformatf("tbl%0d_level", i), 64'(level_o),    64'(tbl[i].lvl));
            chk($sformatf("tbl%0d_full", i),  64'(full_o),     64'(tbl[i].full));
            chk($sformatf("tbl%0d_ovf", i),   64'(overflow_o), 64'(tbl[i].ovf));
            chk($sformatf("tbl%0d_trig", i),  64'(trig_o),     64'(tbl[i].trig));
        end
        push_i = 1'b0;
        clr_i  = 1'b0;
        chk("clr_inflight_busy", 64'(busy_o), 64'd1);
        ready_i = 1'b1;
        tick();
        tick();
        chk("clr_done_busy", 64'(busy_o), 64'd0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (trig_o) cnt++;
        end
        chk("clr_no_trig", 64'(cnt), 64'd0);

        // Three back-to-back commands with an 80-cycle ready-low driver
        for (int i = 0; i < 3; i++) begin
            data_i = dv(10 + i);
            push_i = 1'b1;
            sb_q.push_back(data_i);
            tick();
            chk($sformatf("b2b_push%0d_trig", i), 64'(trig_o), 64'(i == 1));
        end
        push_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ready_i = 1'b0;
            bad = 0;
            for (int k = 0; k < 80; k++) begin
                tick();
                if (trig_o) bad++;
            end
            chk($sformatf("b2b%0d_no_trig_low", c), 64'(bad), 64'd0);
            ready_i = 1'b1;
            tick();
            chk($sformatf("b2b%0d_settle_trig", c), 64'(trig_o), 64'd0);
            tick();
            chk($sformatf("b2b%0d_idle_trig", c), 64'(trig_o), 64'd0);
            tick();
            chk($sformatf("b2b%0d_next_trig", c), 64'(trig_o), 64'(c < 2));
        end
        chk("b2b_busy_end", 64'(busy_o), 64'd0);

        // Reset during WAIT_HI with two entries queued
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i = dv(20 + i);
            push_i = 1'b1;
            sb_q.push_back(data_i);
            tick();
        end
        push_i = 1'b0;
        tick();
        chk("mid_level", 64'(level_o), 64'd2);
        iReset = 1'b1;
        tick();
        sb_q.delete();
        chk("mid_rst_level", 64'(level_o), 64'd0);
        chk("mid_rst_busy",  64'(busy_o),  64'd0);
        chk("mid_rst_addr",  64'(addr_o),  64'd0);
        chk("mid_rst_cmd",   64'(cmd_o),   64'd0);
        chk("mid_rst_trig",  64'(trig_o),  64'd0);
        chk("mid_rst_full",  64'(full_o),  64'd0);
        chk("mid_rst_ovf",   64'(overflow_o), 64'd0);
        chk("mid_rst_err",   64'(err_timeout_o), 64'd0);
        iReset  = 1'b0;
        ready_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (trig_o) cnt++;
        end
        chk("mid_rst_no_trig", 64'(cnt), 64'd0);

`ifdef DDS_SEQ_TIMEOUT_EN
        // Timeout: ready_i stuck high after trig
        data_i = dv(30);
        push_i = 1'b1;
        sb_q.push_back(data_i);
        tick();
        data_i = dv(31);
        sb_q.push_back(data_i);
        tick();
        push_i = 1'b0;
        chk("tmo_trig0", 64'(trig_o), 64'd1);
        tick();
        chk("tmo_err_entry", 64'(err_timeout_o), 64'd0);
        bad = 0;
        for (int k = 1; k < 10; k++) begin
            tick();
            if (err_timeout_o) bad++;
        end
        chk("tmo_err_early", 64'(bad), 64'd0);
        tick();
        chk("tmo_err_set", 64'(err_timeout_o), 64'd1);
        chk("tmo_busy", 64'(busy_o), 64'd1);
        tick();
        chk("tmo_next_trig", 64'(trig_o), 64'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("tmo_clr", 64'(err_timeout_o), 64'd0);
        cnt = 0;
        while (!err_timeout_o && cnt < 30) begin
            tick();
            cnt++;
        end
        chk("tmo_second_cycles", 64'(cnt), 64'd10);
        chk("tmo_second_busy", 64'(busy_o), 64'd0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("tmo_clr2", 64'(err_timeout_o), 64'd0);
`else
        // No timeout: a stuck handshake waits and never flags
        data_i = dv(30);
        push_i = 1'b1;
        sb_q.push_back(data_i);
        tick();
        push_i = 1'b0;
        tick();
        chk("notmo_trig", 64'(trig_o), 64'd1);
        for (int k = 0; k < 30; k++) tick();
        chk("notmo_err", 64'(err_timeout_o), 64'd0);
        chk("notmo_busy", 64'(busy_o), 64'd1);
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        tick();
        tick();
        chk("notmo_done_busy", 64'(busy_o), 64'd0);
`endif

        tick();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
